// File: rtl/uart_time_reporter.sv
// uart_time_reporter: snapshots a time value and writes it to a TX FIFO as ASCII "HH:MM:SS.CC" with optional CR LF
module uart_time_reporter #(
  parameter bit         P_CRLF = 1'b1,
  parameter logic [7:0] P_SEP  = 8'h3A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_report,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_msec,
  input  logic       i_full,
  output logic [7:0] o_wdata,
  output logic       o_wr,
  output logic       o_busy,
  output logic       o_done
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [3:0] LAST = P_CRLF ? 4'd12 : 4'd10;
  state_t     r_state;
  logic [3:0] r_idx;
  logic [4:0] r_hour;
  logic [5:0] r_min, r_sec;
  logic [6:0] r_msec;
  logic [7:0] w_h, w_m, w_s, w_c;
  logic [7:0] w_byte [16];
  assign w_h = {3'd0, r_hour};
  assign w_m = {2'd0, r_min};
  assign w_s = {2'd0, r_sec};
  assign w_c = r_msec > 7'd99 ? 8'd99 : {1'b0, r_msec};
  always_comb begin
    w_byte     = '{default: 8'h00};
    w_byte[0]  = 8'h30 + w_h / 8'd10;
    w_byte[1]  = 8'h30 + w_h % 8'd10;
    w_byte[2]  = P_SEP;
    w_byte[3]  = 8'h30 + w_m / 8'd10;
    w_byte[4]  = 8'h30 + w_m % 8'd10;
    w_byte[5]  = P_SEP;
    w_byte[6]  = 8'h30 + w_s / 8'd10;
    w_byte[7]  = 8'h30 + w_s % 8'd10;
    w_byte[8]  = 8'h2E;
    w_byte[9]  = 8'h30 + w_c / 8'd10;
    w_byte[10] = 8'h30 + w_c % 8'd10;
    w_byte[11] = 8'h0D;
    w_byte[12] = 8'h0A;
  end
  assign o_wr    = r_state == SEND && !i_full;
  assign o_wdata = r_state == SEND ? w_byte[r_idx] : 8'h00;
  assign o_busy  = r_state != IDLE;
  assign o_done  = r_state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_msec  <= '0;
    end else
      case (r_state)
        IDLE: if (i_report) begin
          r_state <= SEND;
          r_idx   <= '0;
          r_hour  <= i_hour;
          r_min   <= i_min;
          r_sec   <= i_sec;
          r_msec  <= i_msec;
        end
        SEND: if (!i_full) begin
          r_idx <= r_idx + 4'd1;
          if (r_idx == LAST) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
endmodule
